// File: rtl/sram_ctrl.sv
// Sequences 32-bit loads/stores onto a 16-bit SRAM as two half-word phases.
// Optional access counters (rd_count/wr_count) are built when SRAM_STATS_EN is defined.
module sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
`ifdef SRAM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        op_wr;
  logic [15:0] wdata_hi;
  logic [31:0] word_off;
  logic        req;
  logic        last;
  logic        active;
  logic        unused_ok;

  assign word_off  = address - ADDR_BASE;
  assign req       = rd_en | wr_en;
  assign last      = (cnt == LAST);
  assign active    = (state == LOW) || (state == HIGH);
  // Only word_off[18:2] forms the half-word address; the rest is intentionally dropped.
  assign unused_ok = ^{word_off[31:19], word_off[1:0]};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_next = LOW;
          cnt_next   = 4'd0;
        end
      end
      LOW: begin
        if (last) begin
          state_next = HIGH;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (active) begin
      sram_we_n  = ~op_wr;
      sram_dq_oe = op_wr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      op_wr       <= 1'b0;
      wdata_hi    <= 16'h0;
      read_data   <= 32'h0;
      sram_addr   <= 18'h0;
      sram_dq_out <= 16'h0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      case (state)
        IDLE: if (req) begin
          // Operation, address and high data half are frozen for the whole access.
          op_wr     <= wr_en;
          wdata_hi  <= write_data[31:16];
          sram_addr <= {word_off[18:2], 1'b0};
          if (wr_en) sram_dq_out <= write_data[15:0];
        end
        LOW: if (last) begin
          sram_addr[0] <= 1'b1;
          if (op_wr) sram_dq_out <= wdata_hi;
          else       read_data[15:0] <= sram_dq_in;
        end
        HIGH: if (last && !op_wr) read_data[31:16] <= sram_dq_in;
        default: ;
      endcase
    end
  end

`ifdef SRAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 16'h0;
      wr_count <= 16'h0;
    end else if (state == HIGH && last) begin
      if (op_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (!op_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: table of single accesses plus reset, back-to-back and WAIT_CYCLES=1 wrap cases.
module tb_sram_ctrl;

  localparam int W = 2;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_wr;
    logic [17:0] a_lo;
    logic [15:0] d_lo;
    logic [15:0] d_hi;
    logic [31:0] rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;

  logic [31:0] read_data0, read_data1;
  logic        ready0, ready1;
  logic [17:0] sram_addr0, sram_addr1;
  logic [15:0] dq_out0, dq_out1, dq_in0, dq_in1;
  logic        oe0, oe1, we_n0, we_n1;
`ifdef SRAM_STATS_EN
  logic [15:0] rd_count0, wr_count0, rd_count1, wr_count1;
`endif

  logic [15:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
    .sram_dq_oe(oe0), .sram_we_n(we_n0)
`ifdef SRAM_STATS_EN
    , .rd_count(rd_count0), .wr_count(wr_count0)
`endif
  );

  sram_ctrl #(.WAIT_CYCLES(1), .ADDR_BASE(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
    .sram_dq_oe(oe1), .sram_we_n(we_n1)
`ifdef SRAM_STATS_EN
    , .rd_count(rd_count1), .wr_count(wr_count1)
`endif
  );

  // Small SRAM model for dut0; dut1 always reads a fixed pattern.
  assign dq_in0 = mem[sram_addr0[5:0]];
  assign dq_in1 = 16'hA5A5;

  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 16'hBEEF;
      mem[5] <= 16'hDEAD;
    end else if (!we_n0) begin
      mem[sram_addr0[5:0]] <= dq_out0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
    @(negedge clk);
    check($sformatf("v%0d ready_c0", idx), 32'(ready0), 32'd0);
    for (int k = 1; k <= 2 * W + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        address = 32'hFFFF_FFFC;
        write_data = 32'h0;
      end
      @(negedge clk);
      if (k <= 2 * W) begin
        check($sformatf("v%0d ready_c%0d", idx, k), 32'(ready0), 32'd0);
        check($sformatf("v%0d addr_c%0d", idx, k), 32'(sram_addr0),
              32'(k > W ? (v.a_lo | 18'd1) : v.a_lo));
        check($sformatf("v%0d we_n_c%0d", idx, k), 32'(we_n0), 32'(!v.is_wr));
        check($sformatf("v%0d oe_c%0d", idx, k), 32'(oe0), 32'(v.is_wr));
        if (v.is_wr)
          check($sformatf("v%0d dq_out_c%0d", idx, k), 32'(dq_out0), 32'(k > W ? v.d_hi : v.d_lo));
      end else begin
        check($sformatf("v%0d ready_done", idx), 32'(ready0), 32'd1);
        check($sformatf("v%0d we_n_done", idx), 32'(we_n0), 32'd1);
        check($sformatf("v%0d oe_done", idx), 32'(oe0), 32'd0);
        check($sformatf("v%0d read_data_done", idx), read_data0, v.rdata);
      end
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d ready_idle", idx), 32'(ready0), 32'd1);
    check($sformatf("v%0d read_data_hold", idx), read_data0, v.rdata);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b1, 18'd4, 16'hBEEF, 16'hDEAD, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 18'd4, 16'h0,    16'h0,    32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b1, 18'd0, 16'h5678, 16'h1234, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b1, 18'd6, 16'hF00D, 16'hCAFE, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1036, 32'h0,        1'b0, 18'd6, 16'h0,    16'h0,    32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'd1027, 32'h0,        1'b0, 18'd0, 16'h0,    16'h0,    32'h12345678};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst ready", 32'(ready0), 32'd1);
    check("rst we_n", 32'(we_n0), 32'd1);
    check("rst oe", 32'(oe0), 32'd0);
    check("rst read_data", read_data0, 32'h0);
    check("rst sram_addr", 32'(sram_addr0), 32'h0);
    check("rst dq_out", 32'(dq_out0), 32'h0);

    // Reset during the HIGH phase of a write
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    check("abort pre we_n", 32'(we_n0), 32'd0);
    check("abort pre addr", 32'(sram_addr0), 32'd5);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort we_n", 32'(we_n0), 32'd1);
    check("abort oe", 32'(oe0), 32'd0);
    check("abort read_data", read_data0, 32'h0);
    check("abort ready", 32'(ready0), 32'd1);

    for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

    // Back-to-back reads: rd_en held across DONE
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1032;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b ready_c%0d", c), 32'(ready0), 32'((c == 5) || (c == 11)));
      if (c == 5 || c == 11) begin
        check($sformatf("b2b read_data_c%0d", c), read_data0, 32'hDEADBEEF);
`ifdef SRAM_STATS_EN
        check($sformatf("b2b rd_count_c%0d", c), 32'(rd_count0), (c == 5) ? 32'd4 : 32'd5);
        check($sformatf("b2b wr_count_c%0d", c), 32'(wr_count0), 32'd3);
`endif
      end
    end
    @(posedge clk); #1 rd_en = 1'b0;

    // WAIT_CYCLES = 1 instance, address below ADDR_BASE wraps
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b1; address = 32'd0;
    @(negedge clk);
    check("w1 ready_c0", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w1 ready_c1", 32'(ready1), 32'd0);
    check("w1 addr_lo", 32'(sram_addr1), 32'h3FE00);
    check("w1 we_n_c1", 32'(we_n1), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("w1 ready_c2", 32'(ready1), 32'd0);
    check("w1 addr_hi", 32'(sram_addr1), 32'h3FE01);
    @(posedge clk); #1 rd_en = 1'b0;
    @(negedge clk);
    check("w1 ready_c3", 32'(ready1), 32'd1);
    check("w1 read_data", read_data1, 32'hA5A5A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
